host_link: RTL and testbench
============================

# host_link

Host-side end of the UART command link: issues one command byte on `tx_o` and collects the single response byte returned on `rx_i` by the ADC controller (8N1, 16× oversampled).
- Used as the synthesizable host model in system benches, or on a second FPGA that drives the ADC board.
- Self-contained serializer/deserializer sharing one sequencing FSM.
- Half duplex, one outstanding transaction.

## Interface
Parameters:
- `Nbits`, 8, data bits per frame
- `Sticks`, 16, `tick_i` pulses per bit; must be even, ≥4
- `ToWidth`, 16, timeout counter width
- `ToTicks`, 32000, `tick_i` pulses allowed in RX_WAIT before timeout; must be ≤ 2^ToWidth−1

Ports:
- `clk_i` in 1: system clock
- `rst_i` in 1: reset; one clock, synchronous, active-high
- `tick_i` in 1: oversampling strobe, one `clk_i` cycle wide
- `req_i` in 1: start transaction; sampled only in IDLE
- `cmd_i` in Nbits: command byte, captured when `req_i` is accepted
- `rx_i` in 1: serial response line, asynchronous
- `tx_o` out 1: serial command line, idle high
- `busy_o` out 1: high in every state except IDLE
- `rsp_o` out Nbits: last valid response byte, held until the next valid response
- `rsp_valid_o` out 1: one-cycle pulse, response captured
- `timeout_o` out 1: one-cycle pulse, no start bit within ToTicks
- `frame_err_o` out 1: one-cycle pulse, stop bit sampled low

## Operation
- States: IDLE, TX_START, TX_DATA, TX_STOP, RX_WAIT, RX_START, RX_DATA, RX_STOP.
- IDLE:
  - `req_i`=1 latches `cmd_i` into the shift register, clears the tick and bit counters, and moves to TX_START.
  - `req_i` in any other state is ignored.
- TX_START, TX_DATA, TX_STOP: each bit period is exactly Sticks `tick_i` pulses.
  - TX_START: `tx_o`=0.
  - TX_DATA: Nbits data bits, LSB first.
  - TX_STOP: `tx_o`=1 for one bit period, then go to RX_WAIT and clear the timeout counter.
- RX_WAIT:
  - On each `tick_i`, the timeout counter increments.
  - If the synchronised rx is 0 on a `tick_i`, go to RX_START.
  - Else, if the counter reaches ToTicks, pulse `timeout_o` and return to IDLE.
  - Falling edges that arrive during TX states are ignored.
- RX_START: after Sticks/2−1 further ticks, re-sample rx.
  - rx=1: glitch; return to RX_WAIT. The timeout counter keeps its value.
  - rx=0: go to RX_DATA.
- RX_DATA: sample one bit every Sticks ticks, LSB shifted in first, for Nbits bits.
- RX_STOP: sample after Sticks ticks.
  - rx=1: load `rsp_o` and pulse `rsp_valid_o`.
  - rx=0: pulse `frame_err_o`; `rsp_o` is unchanged.
  - Either way, return to IDLE.
- Width rules:
  - Tick counter: clog2(Sticks) bits.
  - Bit counter: clog2(Nbits+1) bits.
  - Timeout counter saturates; it never wraps.

## Timing
- Reset values:
  - `tx_o`=1, `busy_o`=0, `rsp_o`=0.
  - `rsp_valid_o`, `timeout_o`, `frame_err_o` = 0.
  - State IDLE; all counters and the shift register cleared.
- Reset mid-frame: at the next edge `tx_o`=1 and state is IDLE; no pulse is emitted.
- `rx_i` passes a 2-flop synchroniser, adding 2 `clk_i` of latency before any sampling decision.
- Transmit timing:
  - `busy_o` and `tx_o`=0 are asserted in the cycle after `req_i` is accepted.
  - Frame length is (Nbits+2)·Sticks ticks.
- Status pulses (`rsp_valid_o`, `timeout_o`, `frame_err_o`) rise in the cycle after the deciding `tick_i`. `busy_o` falls in that same cycle.
- Back-to-back: `req_i` held high in the cycle `busy_o` falls is accepted one cycle later (IDLE entry).
- Start bit detected on the same tick the timeout would expire: start wins, no timeout.
- `tick_i` asserted in every cycle is legal: one bit = Sticks clocks.

## Configuration
- `HOST_LINK_TIMEOUT_EN` defined: timeout counter, ToTicks/ToWidth logic and `timeout_o` behave as above.
- Undefined:
  - The counter is not built and RX_WAIT waits indefinitely.
  - `timeout_o` remains a port tied to 0.
  - `rst_i` is the only exit from a hung RX_WAIT.

## Structure
- Package `host_link_pkg`:
  - state enum typedef;
  - localparams for the Sticks/2−1 mid-bit offset;
  - UART line levels (IDLE=1, START=0, STOP=1).
- One sub-module, `host_link_sync`: 2-flop synchroniser, reset value 1.
- The FSM, counters and shared shift register stay in `host_link`.

## Test plan
All scenarios use `tick_i`=1 every cycle and Sticks=16.
- Transmit framing: `req_i` with `cmd_i`=0xA5 → `tx_o` shows 0 for 16 clocks, then bits 1,0,1,0,0,1,0,1 at 16 clocks each, then 1. `busy_o` is high throughout.
- Normal response: after TX_STOP, drive a 0x3C frame on `rx_i` → `rsp_o`=0x3C with a one-cycle `rsp_valid_o`, 2+(10·16−8) clocks after the start edge ±1. `busy_o`=0 in the same cycle.
- Timeout: `rx_i` held high, ToTicks=100 → `timeout_o` pulses exactly 100 ticks after RX_WAIT entry. With the macro undefined, no pulse and `busy_o` stays 1.
- Glitch then valid frame: a 4-clock low pulse, then a 0x81 frame → no error, `rsp_o`=0x81.
- Frame error: a 0x55 frame with the stop bit driven 0 → `frame_err_o` pulse, `rsp_o` keeps its previous value.
- Reset mid-TX and ignored request:
  - `rst_i` during TX_DATA bit 3 → `tx_o`=1, `busy_o`=0 next cycle, no pulses.
  - A subsequent `req_i` with 0x0F transmits correctly.
  - `req_i` asserted during RX_WAIT is ignored.

Source files
------------

// File: rtl/host_link_pkg.sv
// Shared types and constants for the host-side UART command link.
// States, line levels and the mid-bit sampling offset used by host_link.
package host_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_START = 3'd1,
        ST_TX_DATA  = 3'd2,
        ST_TX_STOP  = 3'd3,
        ST_RX_WAIT  = 3'd4,
        ST_RX_START = 3'd5,
        ST_RX_DATA  = 3'd6,
        ST_RX_STOP  = 3'd7
    } state_t;

    localparam int   DEFAULT_STICKS = 16;
    localparam logic LINE_IDLE      = 1'b1;
    localparam logic LINE_START     = 1'b0;
    localparam logic LINE_STOP      = 1'b1;

    // Ticks to wait after start-bit detection before re-sampling mid-bit.
    function automatic int mid_offset(input int sticks);
        return (sticks / 2) - 1;
    endfunction

endpackage

// File: rtl/host_link_sync.sv
// Two-flop synchroniser for the asynchronous response line.
// Resets to the idle (high) line level so no false start is seen after reset.
module host_link_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Metastability chain, held at line-idle during reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/host_link.sv
// Host end of the UART command link: sends one command byte, collects one response byte.
// Optional build macro HOST_LINK_TIMEOUT_EN adds the RX_WAIT timeout counter and timeout_o.
module host_link
    import host_link_pkg::*;
#(
    parameter int Nbits   = 8,
    parameter int Sticks  = DEFAULT_STICKS,
    parameter int ToWidth = 16,
    parameter int ToTicks = 32000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             req_i,
    input  logic [Nbits-1:0] cmd_i,
    input  logic             rx_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic [Nbits-1:0] rsp_o,
    output logic             rsp_valid_o,
    output logic             timeout_o,
    output logic             frame_err_o
);

    localparam int TW = $clog2(Sticks);
    localparam int BW = $clog2(Nbits + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(Sticks - 1);
    localparam logic [TW-1:0] MID_LAST  = TW'(mid_offset(Sticks) - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(Nbits - 1);

    if ((ToTicks < 1) || ((ToTicks >> ToWidth) != 0)) begin : g_to_cfg_out_of_range
    end

    state_t           r_state, w_state_nxt;
    logic [TW-1:0]    r_tick_cnt, w_tick_cnt_nxt;
    logic [BW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [Nbits-1:0] r_shift, w_shift_nxt;
    logic [Nbits-1:0] r_rsp, w_rsp_nxt;
    logic             r_tx, w_tx_nxt;
    logic             r_busy;
    logic             r_rsp_valid, w_rsp_valid_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             r_frame_err, w_frame_err_nxt;
    logic             w_rx;
    logic             w_bit_end;
    logic             w_to_hit;

    host_link_sync u_sync (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (rx_i),
        .o_q   (w_rx)
    );

    assign w_bit_end = tick_i && (r_tick_cnt == TICK_LAST);

`ifdef HOST_LINK_TIMEOUT_EN
    localparam logic [ToWidth-1:0] TO_LAST = ToWidth'(ToTicks - 1);
    logic [ToWidth-1:0] r_to_cnt;

    assign w_to_hit = (r_to_cnt >= TO_LAST);

    // Timeout counter: cleared while the stop bit goes out, counts idle-line ticks in RX_WAIT, saturates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_to_cnt <= {ToWidth{1'b0}};
        end else if (r_state == ST_TX_STOP) begin
            r_to_cnt <= {ToWidth{1'b0}};
        end else if ((r_state == ST_RX_WAIT) && tick_i && w_rx && (r_to_cnt != {ToWidth{1'b1}})) begin
            r_to_cnt <= r_to_cnt + ToWidth'(1);
        end else begin
            r_to_cnt <= r_to_cnt;
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    // Sequencing FSM: next state, counters, shared shift register and next output values.
    always_comb begin
        w_state_nxt     = r_state;
        w_tick_cnt_nxt  = r_tick_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_rsp_nxt       = r_rsp;
        w_tx_nxt        = r_tx;
        w_rsp_valid_nxt = 1'b0;
        w_timeout_nxt   = 1'b0;
        w_frame_err_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req_i) begin
                    w_state_nxt    = ST_TX_START;
                    w_shift_nxt    = cmd_i;
                    w_tick_cnt_nxt = {TW{1'b0}};
                    w_bit_cnt_nxt  = {BW{1'b0}};
                    w_tx_nxt       = LINE_START;
                end else begin
                    w_tx_nxt       = LINE_IDLE;
                end
            end
            ST_TX_START: begin
                if (w_bit_end) begin
                    w_state_nxt    = ST_TX_DATA;
                    w_tick_cnt_nxt = {TW{1'b0}};
                    w_tx_nxt       = r_shift[0];
                end else if (tick_i) begin
                    w_tick_cnt_nxt = r_tick_cnt + TW'(1);
                end else begin
                    w_tick_cnt_nxt = r_tick_cnt;
                end
            end
            ST_TX_DATA: begin
                if (w_bit_end) begin
                    w_tick_cnt_nxt = {TW{1'b0}};
                    w_bit_cnt_nxt  = r_bit_cnt + BW'(1);
                    w_shift_nxt    = r_shift >> 1;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt = ST_TX_STOP;
                        w_tx_nxt    = LINE_STOP;
                    end else begin
                        w_tx_nxt    = w_shift_nxt[0];
                    end
                end else if (tick_i) begin
                    w_tick_cnt_nxt = r_tick_cnt + TW'(1);
                end else begin
                    w_tick_cnt_nxt = r_tick_cnt;
                end
            end
            ST_TX_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt    = ST_RX_WAIT;
                    w_tick_cnt_nxt = {TW{1'b0}};
                end else if (tick_i) begin
                    w_tick_cnt_nxt = r_tick_cnt + TW'(1);
                end else begin
                    w_tick_cnt_nxt = r_tick_cnt;
                end
            end
            ST_RX_WAIT: begin
                // A start bit on the expiring tick takes priority over the timeout.
                if (tick_i && (w_rx == LINE_START)) begin
                    w_state_nxt    = ST_RX_START;
                    w_tick_cnt_nxt = {TW{1'b0}};
                end else if (tick_i && w_to_hit) begin
                    w_state_nxt    = ST_IDLE;
                    w_timeout_nxt  = 1'b1;
                end else begin
                    w_state_nxt    = ST_RX_WAIT;
                end
            end
            ST_RX_START: begin
                if (tick_i && (r_tick_cnt == MID_LAST)) begin
                    w_tick_cnt_nxt = {TW{1'b0}};
                    w_bit_cnt_nxt  = {BW{1'b0}};
                    if (w_rx == LINE_START) begin
                        w_state_nxt = ST_RX_DATA;
                    end else begin
                        w_state_nxt = ST_RX_WAIT;
                    end
                end else if (tick_i) begin
                    w_tick_cnt_nxt = r_tick_cnt + TW'(1);
                end else begin
                    w_tick_cnt_nxt = r_tick_cnt;
                end
            end
            ST_RX_DATA: begin
                if (w_bit_end) begin
                    w_tick_cnt_nxt = {TW{1'b0}};
                    w_bit_cnt_nxt  = r_bit_cnt + BW'(1);
                    w_shift_nxt    = {w_rx, r_shift[Nbits-1:1]};
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt = ST_RX_STOP;
                    end else begin
                        w_state_nxt = ST_RX_DATA;
                    end
                end else if (tick_i) begin
                    w_tick_cnt_nxt = r_tick_cnt + TW'(1);
                end else begin
                    w_tick_cnt_nxt = r_tick_cnt;
                end
            end
            ST_RX_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt    = ST_IDLE;
                    w_tick_cnt_nxt = {TW{1'b0}};
                    if (w_rx == LINE_STOP) begin
                        w_rsp_nxt       = r_shift;
                        w_rsp_valid_nxt = 1'b1;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                end else if (tick_i) begin
                    w_tick_cnt_nxt = r_tick_cnt + TW'(1);
                end else begin
                    w_tick_cnt_nxt = r_tick_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = LINE_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_tick_cnt  <= {TW{1'b0}};
            r_bit_cnt   <= {BW{1'b0}};
            r_shift     <= {Nbits{1'b0}};
            r_rsp       <= {Nbits{1'b0}};
            r_tx        <= LINE_IDLE;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tick_cnt  <= w_tick_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_rsp       <= w_rsp_nxt;
            r_tx        <= w_tx_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_rsp_valid <= w_rsp_valid_nxt;
            r_timeout   <= w_timeout_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign tx_o        = r_tx;
    assign busy_o      = r_busy;
    assign rsp_o       = r_rsp;
    assign rsp_valid_o = r_rsp_valid;
    assign timeout_o   = r_timeout;
    assign frame_err_o = r_frame_err;

endmodule

// File: tb/tb_host_link.sv
// Directed bench for host_link with a queue of expected status pulses.
// Expectations for the timeout scenario follow HOST_LINK_TIMEOUT_EN.
module tb_host_link;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       req;
    logic [7:0] cmd;
    logic       rx;
    logic       tx_o;
    logic       busy_o;
    logic [7:0] rsp_o;
    logic       rsp_valid_o;
    logic       timeout_o;
    logic       frame_err_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] rsp;
        int         t0;
        int         lo;
        int         hi;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [2:0] K_RSP = 3'b100;
    localparam logic [2:0] K_FERR = 3'b010;
    localparam logic [2:0] K_TO = 3'b001;

    host_link #(
        .Nbits   (8),
        .Sticks  (16),
        .ToWidth (16),
        .ToTicks (100)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tick_i      (tick),
        .req_i       (req),
        .cmd_i       (cmd),
        .rx_i        (rx),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .rsp_o       (rsp_o),
        .rsp_valid_o (rsp_valid_o),
        .timeout_o   (timeout_o),
        .frame_err_o (frame_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Status pulse scoreboard
    always @(negedge clk) begin
        if (rsp_valid_o || frame_err_o || timeout_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, rsp_valid_o, frame_err_o, timeout_o}, 32'd0);
            end else begin
                exp_t e;
                int   lat;
                e   = exp_q.pop_front();
                lat = cyc - e.t0;
                check("pulse_kind", {29'd0, rsp_valid_o, frame_err_o, timeout_o}, {29'd0, e.kind});
                check("rsp_at_pulse", {24'd0, rsp_o}, {24'd0, e.rsp});
                check("busy_at_pulse", {31'd0, busy_o}, 32'd0);
                check("pulse_latency_in_window", {31'd0, (lat >= e.lo) && (lat <= e.hi)}, 32'd1);
            end
        end
    end

    task automatic req_and_check_tx(input logic [7:0] c);
        logic [9:0] frame;
        frame = {1'b1, c, 1'b0};
        req = 1'b1;
        cmd = c;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                req = 1'b0;
                check("tx_bit", {31'd0, tx_o}, {31'd0, frame[b]});
                check("tx_busy", {31'd0, busy_o}, 32'd1);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (16) @(negedge clk);
        end
        rx = stop;
        repeat (16) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic push_exp(input logic [2:0] kind, input logic [7:0] r, input int lo, input int hi);
        exp_t e;
        e.kind = kind;
        e.rsp  = r;
        e.t0   = cyc;
        e.lo   = lo;
        e.hi   = hi;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy_o !== 1'b0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int rsp_lat;
        rsp_lat = 2 + (10 * 16 - 8);
        rst  = 1'b1;
        tick = 1'b1;
        req  = 1'b0;
        cmd  = 8'h00;
        rx   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx_o}, 32'd1);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_rsp", {24'd0, rsp_o}, 32'd0);
        check("reset_pulses", {29'd0, rsp_valid_o, frame_err_o, timeout_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Transmit framing, then a normal 0x3C response
        req_and_check_tx(8'hA5);
        repeat (5) @(negedge clk);
        push_exp(K_RSP, 8'h3C, rsp_lat - 1, rsp_lat + 1);
        send_frame(8'h3C, 1'b1);
        wait_idle(40);
        check("rsp_3c", {24'd0, rsp_o}, 32'h3C);

        // Glitch on the line, then a valid 0x81 frame
        @(negedge clk);
        req_and_check_tx(8'h12);
        repeat (5) @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_still_busy", {31'd0, busy_o}, 32'd1);
        push_exp(K_RSP, 8'h81, rsp_lat - 1, rsp_lat + 1);
        send_frame(8'h81, 1'b1);
        wait_idle(40);
        check("rsp_81", {24'd0, rsp_o}, 32'h81);

        // Frame error keeps the previous response
        @(negedge clk);
        req_and_check_tx(8'h5A);
        repeat (5) @(negedge clk);
        push_exp(K_FERR, 8'h81, rsp_lat - 1, rsp_lat + 1);
        send_frame(8'h55, 1'b0);
        wait_idle(40);
        check("rsp_kept_after_ferr", {24'd0, rsp_o}, 32'h81);

        // Reset during data bit 3
        @(negedge clk);
        req = 1'b1;
        cmd = 8'hC3;
        @(negedge clk);
        req = 1'b0;
        repeat (69) @(negedge clk);
        check("mid_tx_bit3", {31'd0, tx_o}, 32'd0);
        check("mid_tx_busy", {31'd0, busy_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_tx", {31'd0, tx_o}, 32'd1);
        check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        check("rst_mid_rsp", {24'd0, rsp_o}, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_mid_idle_tx", {31'd0, tx_o}, 32'd1);
        req_and_check_tx(8'h0F);
        repeat (5) @(negedge clk);
        push_exp(K_RSP, 8'hE7, rsp_lat - 1, rsp_lat + 1);
        send_frame(8'hE7, 1'b1);
        wait_idle(40);
        check("rsp_e7", {24'd0, rsp_o}, 32'hE7);

        // Request during RX_WAIT is ignored; then timeout (or hang when not built)
        @(negedge clk);
`ifdef HOST_LINK_TIMEOUT_EN
        push_exp(K_TO, 8'hE7, 10 * 16 + 100 + 1, 10 * 16 + 100 + 1);
`endif
        req_and_check_tx(8'h99);
        repeat (10) @(negedge clk);
        req = 1'b1;
        cmd = 8'h00;
        @(negedge clk);
        req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("ignored_req_tx", {31'd0, tx_o}, 32'd1);
            check("ignored_req_busy", {31'd0, busy_o}, 32'd1);
        end
`ifdef HOST_LINK_TIMEOUT_EN
        wait_idle(150);
        check("rsp_kept_after_timeout", {24'd0, rsp_o}, 32'hE7);
`else
        repeat (300) @(negedge clk);
        check("hung_rx_wait_busy", {31'd0, busy_o}, 32'd1);
        check("hung_rx_wait_to", {31'd0, timeout_o}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("hung_reset_busy", {31'd0, busy_o}, 32'd0);
`endif

        repeat (5) @(negedge clk);
        check("all_pulses_seen", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
